// File: rtl/fp_mul_nr_pipe.sv
// fp_mul_nr_pipe
// Pipelined sign-less floating-point multiplier for the Newton-Raphson
// inverse-square-root datapath. It multiplies the correction term (1.5 - h)
// by the delayed estimate y to produce the refined estimate. A companion word
// (the estimate itself) travels alongside with identical latency.
//
// Word format: [EXP_W+MAN_W-1:MAN_W] biased exponent, [MAN_W-1:0] fraction,
// hidden leading one. Exponent 0 (including denormals) is treated as zero.
// The all-ones exponent is treated as infinity. Rounding is to nearest, ties
// to even. Underflow flushes to zero.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   valid           operand pair valid this cycle
//   float_in        operand A (correction term)
//   float_in_delay  operand B (estimate), also the pass-through word
//   float_out       rounded A*B, held between results
//   float_out_delay float_in_delay aligned with float_out, held between results
//   ready           one-cycle strobe per accepted input, 3 cycles after sampling
module fp_mul_nr_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic [EXP_W+MAN_W-1:0] float_in,
    input  logic [EXP_W+MAN_W-1:0] float_in_delay,
    output logic [EXP_W+MAN_W-1:0] float_out,
    output logic [EXP_W+MAN_W-1:0] float_out_delay,
    output logic                   ready
);

    localparam int W       = EXP_W + MAN_W;
    localparam int PW      = 2 * (MAN_W + 1);
    // Two extra exponent bits: one for the sign, one for headroom above the
    // all-ones exponent so overflow is detectable after normalise and round.
    localparam int XW      = EXP_W + 2;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    localparam logic signed [XW-1:0] EXP_LIM  = XW'(EXP_MAX);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic [W-1:0]         INF_WORD = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    // ------------------------------------------------------------------
    // Stage 1: operand decode, full mantissa product, exponent sum
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]     exp_a;
    logic [EXP_W-1:0]     exp_b;
    logic [MAN_W-1:0]     frac_a;
    logic [MAN_W-1:0]     frac_b;
    logic [PW-1:0]        prod_c;
    logic signed [XW-1:0] exp_sum_c;

    assign exp_a  = float_in[W-1:MAN_W];
    assign exp_b  = float_in_delay[W-1:MAN_W];
    assign frac_a = float_in[MAN_W-1:0];
    assign frac_b = float_in_delay[MAN_W-1:0];

    assign prod_c    = PW'({1'b1, frac_a}) * PW'({1'b1, frac_b});
    assign exp_sum_c = XW'(exp_a) + XW'(exp_b) - XW'(BIAS);

    logic                 s1_valid;
    logic                 s1_zero;
    logic                 s1_inf;
    logic [PW-1:0]        s1_prod;
    logic signed [XW-1:0] s1_exp;
    logic [W-1:0]         s1_pass;

    // Stage 1 register: the pass-through word is only captured for valid
    // tokens so the datapath stays quiet during bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_inf   <= 1'b0;
            s1_prod  <= '0;
            s1_exp   <= '0;
            s1_pass  <= '0;
        end else begin
            s1_valid <= valid;
            if (valid) begin
                s1_zero <= (exp_a == '0) || (exp_b == '0);
                s1_inf  <= (exp_a == '1) || (exp_b == '1);
                s1_prod <= prod_c;
                s1_exp  <= exp_sum_c;
                s1_pass <= float_in_delay;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: normalise. The product of two [1,2) mantissas lies in [1,4),
    // so at most one right shift is needed.
    // ------------------------------------------------------------------
    logic [MAN_W-1:0]     norm_mant_c;
    logic                 norm_guard_c;
    logic                 norm_sticky_c;
    logic signed [XW-1:0] norm_exp_c;

    always_comb begin
        norm_mant_c   = s1_prod[PW-3 -: MAN_W];
        norm_guard_c  = s1_prod[PW-3-MAN_W];
        norm_sticky_c = |s1_prod[PW-4-MAN_W:0];
        norm_exp_c    = s1_exp;
        if (s1_prod[PW-1]) begin
            norm_mant_c   = s1_prod[PW-2 -: MAN_W];
            norm_guard_c  = s1_prod[PW-2-MAN_W];
            norm_sticky_c = |s1_prod[PW-3-MAN_W:0];
            norm_exp_c    = s1_exp + EXP_ONE;
        end
    end

    logic                 s2_valid;
    logic                 s2_zero;
    logic                 s2_inf;
    logic [MAN_W-1:0]     s2_mant;
    logic                 s2_guard;
    logic                 s2_sticky;
    logic signed [XW-1:0] s2_exp;
    logic [W-1:0]         s2_pass;

    // Stage 2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_zero   <= 1'b0;
            s2_inf    <= 1'b0;
            s2_mant   <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_exp    <= '0;
            s2_pass   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_zero   <= s1_zero;
                s2_inf    <= s1_inf;
                s2_mant   <= norm_mant_c;
                s2_guard  <= norm_guard_c;
                s2_sticky <= norm_sticky_c;
                s2_exp    <= norm_exp_c;
                s2_pass   <= s1_pass;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round to nearest even. A carry out of the fraction means the
    // mantissa rolled over to 2.0, which is 1.0 with the exponent bumped.
    // ------------------------------------------------------------------
    logic                 round_inc_c;
    logic [MAN_W:0]       round_sum_c;
    logic [MAN_W-1:0]     round_frac_c;
    logic signed [XW-1:0] round_exp_c;

    always_comb begin
        round_inc_c  = s2_guard & (s2_sticky | s2_mant[0]);
        round_sum_c  = {1'b0, s2_mant} + (MAN_W+1)'(round_inc_c);
        round_frac_c = round_sum_c[MAN_W-1:0];
        round_exp_c  = s2_exp;
        if (round_sum_c[MAN_W]) begin
            round_frac_c = '0;
            round_exp_c  = s2_exp + EXP_ONE;
        end
    end

    logic                 s3_valid;
    logic                 s3_zero;
    logic                 s3_inf;
    logic [MAN_W-1:0]     s3_frac;
    logic signed [XW-1:0] s3_exp;
    logic [W-1:0]         s3_pass;

    // Stage 3 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_zero  <= 1'b0;
            s3_inf   <= 1'b0;
            s3_frac  <= '0;
            s3_exp   <= '0;
            s3_pass  <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_zero <= s2_zero;
                s3_inf  <= s2_inf;
                s3_frac <= round_frac_c;
                s3_exp  <= round_exp_c;
                s3_pass <= s2_pass;
            end
        end
    end

    // ------------------------------------------------------------------
    // Classification. Zero beats infinity, so 0 * inf yields zero.
    // ------------------------------------------------------------------
    logic [W-1:0] result_c;

    always_comb begin
        result_c = {s3_exp[EXP_W-1:0], s3_frac};
        if (s3_zero) begin
            result_c = '0;
        end else if (s3_inf) begin
            result_c = INF_WORD;
        end else if (s3_exp >= EXP_LIM) begin
            result_c = INF_WORD;
        end else if (s3_exp <= EXP_ZERO) begin
            result_c = '0;
        end
    end

    // Output register: results are only loaded when a valid token leaves
    // the pipe, so the outputs hold their last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready           <= 1'b0;
            float_out       <= '0;
            float_out_delay <= '0;
        end else begin
            ready <= s3_valid;
            if (s3_valid) begin
                float_out       <= result_c;
                float_out_delay <= s3_pass;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_nr_pipe.sv
// tb_fp_mul_nr_pipe
// Self-checking bench for fp_mul_nr_pipe: directed vectors with hand-worked
// results, bubble patterns, asynchronous reset mid-flight, and a randomised
// run against an independent round-to-nearest-even reference.
module tb_fp_mul_nr_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [30:0] float_in = '0;
    logic [30:0] float_in_delay = '0;
    logic [30:0] float_out;
    logic [30:0] float_out_delay;
    logic        ready;

    int errors = 0;
    int checks = 0;

    fp_mul_nr_pipe #(.EXP_W(8), .MAN_W(23), .BIAS(127)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid           (valid),
        .float_in        (float_in),
        .float_in_delay  (float_in_delay),
        .float_out       (float_out),
        .float_out_delay (float_out_delay),
        .ready           (ready)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled off the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference multiply written from the arithmetic definition: shift the
    // exact product back to 24 significant bits, compare the remainder
    // against one half for rounding.
    function automatic logic [30:0] ref_mul(input logic [30:0] a, input logic [30:0] b);
        int              ea, eb, e, sh;
        longint unsigned ma, mb, p, keep, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return 31'h0;
        if (ea == 255 || eb == 255) return 31'h7F800000;
        ma = 64'h800000 | 64'(a[22:0]);
        mb = 64'h800000 | 64'(b[22:0]);
        p  = ma * mb;
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        e  = ea + eb - 127 + (sh - 23);
        keep = p >> sh;
        rem  = p - (keep << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep = keep + 1;
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e = e + 1;
        end
        if (e >= 255) return 31'h7F800000;
        if (e <= 0) return 31'h0;
        return {e[7:0], keep[22:0]};
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (ready !== 1'b0 || float_out !== 31'h0 || float_out_delay !== 31'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: ready=%b out=%h dly=%h, want 0/0/0",
                     ready, float_out, float_out_delay);
        end
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (ready !== 1'b0 || float_out !== 31'h0) begin
                errors++;
                $display("[TB] FAIL reset_idle: ready=%b out=%h, want 0/0", ready, float_out);
            end
        end
    endtask

    task automatic test_single();
        valid = 1'b1;
        float_in = 31'h3FC00000;
        float_in_delay = 31'h3FC00000;
        step();
        valid = 1'b0;
        float_in = '0;
        float_in_delay = '0;
        for (int k = 1; k < 3; k++) begin
            step();
            checks++;
            if (ready !== 1'b0 || float_out !== 31'h0 || float_out_delay !== 31'h0) begin
                errors++;
                $display("[TB] FAIL single_latency: cycle %0d ready=%b out=%h, want 0/0", k, ready, float_out);
            end
        end
        step();
        checks++;
        if (ready !== 1'b1 || float_out !== 31'h40100000 || float_out_delay !== 31'h3FC00000) begin
            errors++;
            $display("[TB] FAIL single_result: ready=%b out=%h dly=%h, want 1/40100000/3fc00000",
                     ready, float_out, float_out_delay);
        end
        step();
        checks++;
        if (ready !== 1'b0 || float_out !== 31'h40100000 || float_out_delay !== 31'h3FC00000) begin
            errors++;
            $display("[TB] FAIL single_hold: ready=%b out=%h dly=%h, want 0/40100000/3fc00000",
                     ready, float_out, float_out_delay);
        end
    endtask

    // Four operand pairs issued on consecutive cycles; results must come out
    // on four consecutive ready cycles in order
    task automatic run_burst(input string name, input logic [30:0] va[4],
                             input logic [30:0] vb[4], input logic [30:0] vr[4]);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                valid = 1'b1;
                float_in = va[i];
                float_in_delay = vb[i];
            end else begin
                valid = 1'b0;
            end
            step();
            if (i < 3 || i == 7) begin
                checks++;
                if (ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s_idle: cycle %0d ready=%b, want 0", name, i, ready);
                end
            end else begin
                checks++;
                if (ready !== 1'b1 || float_out !== vr[i-3] || float_out_delay !== vb[i-3]) begin
                    errors++;
                    $display("[TB] FAIL %s_%0d: ready=%b out=%h dly=%h, want 1/%h/%h",
                             name, i - 3, ready, float_out, float_out_delay, vr[i-3], vb[i-3]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [30:0] va[4];
        logic [30:0] vb[4];
        logic [30:0] vr[4];
        va = '{31'h40000000, 31'h3F800001, 31'h3F800800, 31'h3F800000};
        vb = '{31'h3F000000, 31'h3F800001, 31'h3F800800, 31'h3F7FFFFF};
        vr = '{31'h3F800000, 31'h3F800002, 31'h3F801000, 31'h3F7FFFFF};
        run_burst("b2b", va, vb, vr);
    endtask

    task automatic test_specials();
        logic [30:0] va[4];
        logic [30:0] vb[4];
        logic [30:0] vr[4];
        va = '{31'h00000000, 31'h7F000000, 31'h00800000, 31'h00400000};
        vb = '{31'h7F800000, 31'h40000000, 31'h3F000000, 31'h40000000};
        vr = '{31'h00000000, 31'h7F800000, 31'h00000000, 31'h00000000};
        run_burst("special", va, vb, vr);
    endtask

    task automatic test_valid_pattern();
        logic        pat[5];
        logic [30:0] pa[5];
        logic [30:0] pb[5];
        logic [30:0] pr[5];
        logic [30:0] exp_out;
        logic [30:0] exp_dly;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        pa  = '{31'h3FC00000, 31'h7F000000, 31'h40000000, 31'h40400000, 31'h7F000000};
        pb  = '{31'h3FC00000, 31'h7F000000, 31'h3F000000, 31'h40000000, 31'h7F000000};
        pr  = '{31'h40100000, 31'h7F800000, 31'h3F800000, 31'h40C00000, 31'h7F800000};
        // Last special result is a zero with B=0x40000000 as its delay word
        exp_out = 31'h0;
        exp_dly = 31'h40000000;
        for (int i = 0; i < 8; i++) begin
            valid = (i < 5) ? pat[i] : 1'b0;
            float_in = (i < 5) ? pa[i] : 31'h0;
            float_in_delay = (i < 5) ? pb[i] : 31'h0;
            step();
            if (i >= 3) begin
                if (pat[i-3]) begin
                    exp_out = pr[i-3];
                    exp_dly = pb[i-3];
                end
                checks++;
                if (ready !== pat[i-3] || float_out !== exp_out || float_out_delay !== exp_dly) begin
                    errors++;
                    $display("[TB] FAIL pattern_%0d: ready=%b out=%h dly=%h, want %b/%h/%h",
                             i - 3, ready, float_out, float_out_delay, pat[i-3], exp_out, exp_dly);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            float_in = 31'h3F800000;
            float_in_delay = 31'h40000000 + 31'(i);
            step();
        end
        valid = 1'b0;
        float_in = '0;
        float_in_delay = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || float_out !== 31'h0 || float_out_delay !== 31'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: ready=%b out=%h dly=%h, want 0/0/0",
                     ready, float_out, float_out_delay);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (ready !== 1'b0 || float_out !== 31'h0) begin
                errors++;
                $display("[TB] FAIL post_reset_quiet: cycle %0d ready=%b out=%h, want 0/0", k, ready, float_out);
            end
        end
        valid = 1'b1;
        float_in = 31'h40400000;
        float_in_delay = 31'h40400000;
        step();
        valid = 1'b0;
        step();
        step();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_early: ready=%b, want 0", ready);
        end
        step();
        checks++;
        if (ready !== 1'b1 || float_out !== 31'h41100000 || float_out_delay !== 31'h40400000) begin
            errors++;
            $display("[TB] FAIL post_reset_result: ready=%b out=%h dly=%h, want 1/41100000/40400000",
                     ready, float_out, float_out_delay);
        end
    endtask

    task automatic test_random();
        localparam int N = 10000;
        logic [30:0] q_out[$];
        logic [30:0] q_dly[$];
        logic [30:0] a;
        logic [30:0] b;
        logic [30:0] want_out;
        logic [30:0] want_dly;
        for (int i = 0; i < N + 10; i++) begin
            if (i < N) begin
                a = {8'($urandom_range(190, 64)), 23'($urandom)};
                b = {8'($urandom_range(190, 64)), 23'($urandom)};
                valid = 1'b1;
                float_in = a;
                float_in_delay = b;
                q_out.push_back(ref_mul(a, b));
                q_dly.push_back(b);
            end else begin
                valid = 1'b0;
            end
            step();
            if (ready) begin
                checks++;
                if (q_out.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL random_spurious: ready=1 out=%h, want no strobe", float_out);
                end else begin
                    want_out = q_out.pop_front();
                    want_dly = q_dly.pop_front();
                    if (float_out !== want_out || float_out_delay !== want_dly) begin
                        errors++;
                        $display("[TB] FAIL random_result: out=%h dly=%h, want %h/%h",
                                 float_out, float_out_delay, want_out, want_dly);
                    end
                end
            end
        end
        checks++;
        if (q_out.size() != 0) begin
            errors++;
            $display("[TB] FAIL random_drain: %0d results outstanding, want 0", q_out.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_specials();
        test_valid_pattern();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
